// File: rtl/pooling_input_sequencer.sv
// Tags row-major convolution words with {row, feature} and buffers them for the pooling stage.
// Accept-to-strobe latency 2 cycles; data_ready falls when the tag FIFO fills, out_stall holds the FIFO.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

module pooling_input_sequencer #(
  parameter int TOTAL_FEATURE = 4,
  parameter int FEATURE_ROWS  = 6,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic [`DATA_WIDTH-1:0] data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic                   out_stall,
  output logic [`DATA_WIDTH-1:0] data_out,
  output logic [1:0]             feature_idx,
  output logic [2:0]             feature_row,
  output logic                   input_valid,
  output logic                   frame_done,
  output logic                   protocol_err
);
  localparam int DW = `DATA_WIDTH;
  localparam int EW = DW + 5;
  localparam logic [1:0] FEAT_LAST = 2'(TOTAL_FEATURE - 1);
  localparam logic [2:0] ROW_LAST  = 3'(FEATURE_ROWS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    feat_cnt;
  logic [2:0]    row_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          pop;
  logic          last_in;
  logic          last_out;
  logic          start_ok;
  logic [EW-1:0] pop_dat;

  assign accept   = data_valid && data_ready;
  assign pop      = !fifo_empty && !out_stall;
  assign last_in  = (row_cnt == ROW_LAST) && (feat_cnt == FEAT_LAST);
  assign last_out = (pop_dat[EW-1 -: 3] == ROW_LAST) && (pop_dat[DW +: 2] == FEAT_LAST);
  assign start_ok = frame_start && (state == IDLE);

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_dat ({row_cnt, feat_cnt, data_in}),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The tag of the popped entry marks the end of the frame, so no occupancy compare is needed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = RUN;
      RUN:     if (accept && last_in) state_nxt = DRAIN;
      DRAIN:   if (pop && last_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_ready = (state == RUN) && !fifo_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_cnt <= '0;
      row_cnt  <= '0;
    end else if (start_ok) begin
      feat_cnt <= '0;
      row_cnt  <= '0;
    end else if (accept) begin
      if (feat_cnt == FEAT_LAST) begin
        feat_cnt <= '0;
        row_cnt  <= (row_cnt == ROW_LAST) ? 3'd0 : row_cnt + 3'd1;
      end else begin
        feat_cnt <= feat_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      feature_idx <= '0;
      feature_row <= '0;
      input_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      input_valid <= pop;
      frame_done  <= pop && last_out;
      if (pop) begin
        data_out    <= pop_dat[DW-1:0];
        feature_idx <= pop_dat[DW +: 2];
        feature_row <= pop_dat[EW-1 -: 3];
      end
    end
  end

  // Setting wins over clearing when a bad word arrives alongside an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_err <= 1'b0;
    end else begin
      if (start_ok) protocol_err <= 1'b0;
      if ((data_valid && state != RUN) || (frame_start && state != IDLE)) protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pooling_input_sequencer.sv
// Scoreboard bench for pooling_input_sequencer: frame-level reference model feeds an expected-output queue.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_pooling_input_sequencer;
  localparam int TF    = 4;
  localparam int FR    = 6;
  localparam int DEPTH = 4;
  localparam int N     = TF * FR;
  localparam int DW    = `DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          out_stall;
  logic [DW-1:0] data_out;
  logic [1:0]    feature_idx;
  logic [2:0]    feature_row;
  logic          input_valid;
  logic          frame_done;
  logic          protocol_err;

  pooling_input_sequencer #(.TOTAL_FEATURE(TF), .FEATURE_ROWS(FR), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .out_stall    (out_stall),
    .data_out     (data_out),
    .feature_idx  (feature_idx),
    .feature_row  (feature_row),
    .input_valid  (input_valid),
    .frame_done   (frame_done),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            row;
    int            idx;
    bit            last;
  } item_t;

  item_t mf[$];
  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    running, busy, took, iv_m, err_m;
  int    k;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: k-th word of a frame is tagged row k/TF, feature k%TF; buffer holds DEPTH words.
  always @(negedge clk) begin
    bit    ready_m, pop_m, busy_pre, err_n;
    item_t it;
    if (!rst_n) begin
      mf.delete();
      exp_q.delete();
      running = 0; busy = 0; took = 0; iv_m = 0; err_m = 0; k = 0;
    end else begin
      chk("input_valid", 32'(input_valid), 32'(iv_m));
      chk("protocol_err", 32'(protocol_err), 32'(err_m));
      ready_m = running && (mf.size() < DEPTH);
      chk("data_ready", 32'(data_ready), 32'(ready_m));
      busy_pre = busy;
      pop_m = (mf.size() > 0) && !out_stall;
      took  = data_valid && ready_m;
      err_n = err_m;
      if (frame_start && !busy_pre) err_n = 0;
      if ((data_valid && !running) || (frame_start && busy_pre)) err_n = 1;
      if (pop_m) begin
        it = mf.pop_front();
        exp_q.push_back(it);
        if (it.last) busy = 0;
      end
      if (took) begin
        it.d = data_in; it.row = k / TF; it.idx = k % TF; it.last = (k == N - 1);
        mf.push_back(it);
        k++;
        if (k == N) running = 0;
      end
      if (frame_start && !busy_pre) begin
        running = 1; busy = 1; k = 0;
      end
      iv_m  = pop_m;
      err_m = err_n;
    end
  end

  always @(negedge clk) begin
    item_t e;
    if (rst_n) begin
      if (input_valid) begin
        chk("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("data_out", 32'(data_out), 32'(e.d));
          chk("feature_idx", 32'(feature_idx), 32'(e.idx));
          chk("feature_row", 32'(feature_row), 32'(e.row));
          chk("frame_done", 32'(frame_done), 32'(e.last));
        end
      end else begin
        chk("frame_done_without_strobe", 32'(frame_done), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'd0);
    chk({tag, "_feature_idx"}, 32'(feature_idx), 32'd0);
    chk({tag, "_feature_row"}, 32'(feature_row), 32'd0);
    chk({tag, "_input_valid"}, 32'(input_valid), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_protocol_err"}, 32'(protocol_err), 32'd0);
    chk({tag, "_data_ready"}, 32'(data_ready), 32'd0);
  endtask

  task automatic apply_reset();
    #1 rst_n = 1'b0;
    #1 check_zero("reset_mid");
    frame_start = 1'b0; data_valid = 1'b0; out_stall = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
  endtask

  task automatic run_frame(input int vpct, input int spct, input bit alt, input bit directed,
                           input int fs_word, input int stall_word, input int stall_len,
                           input int rst_word);
    int            idx, cyc, stall_left;
    bit            stall_done, fs_done;
    logic [DW-1:0] cur;
    idx = 0; cyc = 0; stall_left = 0; stall_done = 0; fs_done = 0;
    frame_start = 1'b1; data_valid = 1'b0; out_stall = 1'b0;
    step();
    frame_start = 1'b0;
    cur = directed ? DW'(1) : DW'($urandom);
    while (idx < N && cyc < 600) begin
      if (alt) begin
        data_valid = (cyc % 2 == 0);
        out_stall  = ((cyc / 2) % 2 == 1);
      end else begin
        data_valid = ($urandom_range(99) < vpct);
        out_stall  = ($urandom_range(99) < spct);
      end
      if (!stall_done && stall_word >= 0 && idx >= stall_word) begin
        stall_left = stall_len;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        out_stall = 1'b1;
        stall_left--;
      end
      if (!fs_done && idx == fs_word) begin
        frame_start = 1'b1;
        fs_done = 1;
      end
      data_in = cur;
      step();
      frame_start = 1'b0;
      cyc++;
      if (took) begin
        idx++;
        cur = directed ? DW'(idx + 1) : DW'($urandom);
      end
      if (rst_word >= 0 && idx == rst_word) begin
        apply_reset();
        return;
      end
    end
    chk("frame_words_accepted", 32'(idx), 32'(N));
    data_valid = 1'b0;
    cyc = 0;
    while ((busy || exp_q.size() > 0) && cyc < 600) begin
      out_stall   = ($urandom_range(99) < spct);
      frame_start = busy && ($urandom_range(99) < 15);
      step();
      frame_start = 1'b0;
      cyc++;
    end
    out_stall = 1'b0;
    chk("frame_drained", 32'(busy || exp_q.size() > 0), 32'd0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; data_valid = 1'b0; out_stall = 1'b0; data_in = '0;
    #3 check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step();
    data_valid = 1'b1;
    data_in = DW'(16'hDEAD);
    step();
    data_valid = 1'b0;
    repeat (2) step();
    run_frame(100, 0, 0, 1, -1, -1, 0, -1);
    run_frame(100, 0, 0, 1, -1, 8, 10, -1);
    run_frame(100, 10, 0, 0, 7, -1, 0, -1);
    run_frame(0, 0, 1, 0, -1, -1, 0, -1);
    run_frame(100, 0, 0, 0, -1, 7, 20, 10);
    for (int f = 0; f < 6; f++)
      run_frame(int'($urandom_range(100, 30)), int'($urandom_range(60, 0)), 0, 0,
                int'($urandom_range(30, 0)), -1, 0, -1);
    repeat (3) step();
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
